// File: rtl/pred_wb_pkg.sv
// Shared types and defaults for the predicate writeback queue.
// Widths and depth here are the defaults; modules can override them through parameters.
package pred_wb_pkg;

  localparam int PRED_REG_BITS = 2;
  localparam int PRED_DEPTH    = 4;
  localparam int NUM_REG       = 1 << PRED_REG_BITS;
  localparam int CNT_W         = $clog2(PRED_DEPTH) + 1;

  typedef struct packed {
    logic [PRED_REG_BITS-1:0] addr;
    logic                     data;
  } pred_wb_entry_t;

endpackage

// File: rtl/pred_wb_fifo.sv
// Dual-push / single-pop circular buffer with occupancy count; push0 lands ahead of push1.
// Storage, valid mask and read pointer are exported so the parent can decode busy and bypass.
module pred_wb_fifo
  import pred_wb_pkg::*;
#(
  parameter int  DEPTH   = PRED_DEPTH,
  parameter type entry_t = pred_wb_entry_t
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push0,
  input  entry_t                   push0_entry,
  input  logic                     push1,
  input  entry_t                   push1_entry,
  input  logic                     pop,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output entry_t                   entries [DEPTH],
  output logic [DEPTH-1:0]         valid_mask
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int QCNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W-1:0] age;

  assign wr_ptr_nxt = wr_ptr + PTR_W'(1);
  assign head       = entries[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // A lone push1 takes the write slot, so the two producers share one pointer.
      if (push0 | push1) entries[wr_ptr] <= push0 ? push0_entry : push1_entry;
      if (push0 & push1) entries[wr_ptr_nxt] <= push1_entry;
      wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count  <= count + QCNT_W'(push0) + QCNT_W'(push1) - QCNT_W'(pop);
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    valid_mask = '0;
    age        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age           = PTR_W'(i) - rd_ptr;
      valid_mask[i] = {1'b0, age} < count;
    end
  end

endmodule

// File: rtl/predicate_writeback_queue.sv
// Two producers -> in-order FIFO -> one registered predicate RF write per cycle (min latency 1).
// Ready derives from occupancy only, so a same-cycle pop gives no credit; PRED_WB_BYPASS_EN adds q_addr/q_hit/q_data lookup.
module predicate_writeback_queue
  import pred_wb_pkg::*;
#(
  parameter int REG_BITS = PRED_REG_BITS,
  parameter int DEPTH    = PRED_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [REG_BITS-1:0]        a_addr,
  input  logic                       a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [REG_BITS-1:0]        b_addr,
  input  logic                       b_data,
  output logic                       wr_en,
  output logic [REG_BITS-1:0]        wr_addr,
  output logic                       wr_data,
  output logic [(1<<REG_BITS)-1:0]   busy,
  output logic [$clog2(DEPTH):0]     count
`ifdef PRED_WB_BYPASS_EN
  ,
  input  logic [REG_BITS-1:0]        q_addr,
  output logic                       q_hit,
  output logic                       q_data
`endif
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam int                QCNT_W  = PTR_W + 1;
  localparam logic [QCNT_W-1:0] DEPTH_C = QCNT_W'(DEPTH);

  typedef struct packed {
    logic [REG_BITS-1:0] addr;
    logic                data;
  } entry_t;

  entry_t              a_entry;
  entry_t              b_entry;
  entry_t              head;
  entry_t              entries [DEPTH];
  logic [DEPTH-1:0]    valid_mask;
  logic [PTR_W-1:0]    rd_ptr;
  logic [QCNT_W-1:0]   free;
  logic                push_a;
  logic                push_b;
  logic                pop;

  assign a_entry = '{addr: a_addr, data: a_data};
  assign b_entry = '{addr: b_addr, data: b_data};

  assign free    = DEPTH_C - count;
  assign a_ready = (free != '0) & ~flush;
  // B must leave room for A when both present, since A is enqueued first.
  assign b_ready = (a_valid ? (free >= QCNT_W'(2)) : (free != '0)) & ~flush;
  assign push_a  = a_valid & a_ready;
  assign push_b  = b_valid & b_ready;
  assign pop     = (count != '0) & ~flush;

  pred_wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .push0       (push_a),
    .push0_entry (a_entry),
    .push1       (push_b),
    .push1_entry (b_entry),
    .pop         (pop),
    .head        (head),
    .count       (count),
    .rd_ptr      (rd_ptr),
    .entries     (entries),
    .valid_mask  (valid_mask)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= 1'b0;
    end else if (pop) begin
      wr_en   <= 1'b1;
      wr_addr <= head.addr;
      wr_data <= head.data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++)
      if (valid_mask[i]) busy[entries[i].addr] = 1'b1;
    if (wr_en) busy[wr_addr] = 1'b1;
  end

`ifdef PRED_WB_BYPASS_EN
  logic [PTR_W-1:0] scan_idx;

  // Scan oldest to youngest so later matches overwrite earlier ones.
  always_comb begin
    q_hit    = 1'b0;
    q_data   = 1'b0;
    scan_idx = rd_ptr;
    if (wr_en && (wr_addr == q_addr)) begin
      q_hit  = 1'b1;
      q_data = wr_data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = rd_ptr + PTR_W'(k);
      if ((QCNT_W'(k) < count) && (entries[scan_idx].addr == q_addr)) begin
        q_hit  = 1'b1;
        q_data = entries[scan_idx].data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_predicate_writeback_queue.sv
// Randomized and directed bench for predicate_writeback_queue against a queue-based reference model.
`timescale 1ns/1ps
module tb_predicate_writeback_queue;

  localparam int RB    = 2;
  localparam int DEPTH = 4;
  localparam int NR    = 1 << RB;

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic          a_valid, a_data, b_valid, b_data;
  logic [RB-1:0] a_addr, b_addr;
  logic          a_ready, b_ready, wr_en, wr_data;
  logic [RB-1:0] wr_addr;
  logic [NR-1:0] busy;
  logic [2:0]    count;
`ifdef PRED_WB_BYPASS_EN
  logic [RB-1:0] q_addr;
  logic          q_hit, q_data;
`endif

  typedef struct {
    logic [RB-1:0] addr;
    logic          data;
  } ent_t;

  ent_t          mq[$];
  logic          m_wr_en;
  logic [RB-1:0] m_wr_addr;
  logic          m_wr_data;
  logic          dut_rf [NR];
  logic          a_acc, b_acc;
  int            n_checks, n_fail, n_writes;

  predicate_writeback_queue #(.REG_BITS(RB), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .count   (count)
`ifdef PRED_WB_BYPASS_EN
    ,
    .q_addr  (q_addr),
    .q_hit   (q_hit),
    .q_data  (q_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_wr_en   = 1'b0;
    m_wr_addr = '0;
    m_wr_data = 1'b0;
    a_acc     = 1'b0;
    b_acc     = 1'b0;
  endtask

  // One clock: check combinational outputs at negedge, advance model, check registered outputs after posedge.
  task automatic tick();
    int            free;
    logic          exp_ar, exp_br;
    logic [NR-1:0] exp_busy;
    ent_t          e;
`ifdef PRED_WB_BYPASS_EN
    logic          exp_hit, exp_qd;
`endif
    @(negedge clk);
    free     = DEPTH - mq.size();
    exp_ar   = (free >= 1) && !flush;
    exp_br   = (free >= (a_valid ? 2 : 1)) && !flush;
    exp_busy = '0;
    foreach (mq[i]) exp_busy[mq[i].addr] = 1'b1;
    if (m_wr_en) exp_busy[m_wr_addr] = 1'b1;
    n_checks++;
    if (a_ready !== exp_ar) begin n_fail++; $display("FAIL a_ready t=%0t got %b exp %b", $time, a_ready, exp_ar); end
    n_checks++;
    if (b_ready !== exp_br) begin n_fail++; $display("FAIL b_ready t=%0t got %b exp %b", $time, b_ready, exp_br); end
    n_checks++;
    if (count !== 3'(mq.size())) begin n_fail++; $display("FAIL count t=%0t got %0d exp %0d", $time, count, mq.size()); end
    n_checks++;
    if (busy !== exp_busy) begin n_fail++; $display("FAIL busy t=%0t got %b exp %b", $time, busy, exp_busy); end
`ifdef PRED_WB_BYPASS_EN
    exp_hit = 1'b0;
    exp_qd  = 1'b0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (!exp_hit && mq[i].addr == q_addr) begin exp_hit = 1'b1; exp_qd = mq[i].data; end
    if (!exp_hit && m_wr_en && m_wr_addr == q_addr) begin exp_hit = 1'b1; exp_qd = m_wr_data; end
    n_checks++;
    if (q_hit !== exp_hit || q_data !== exp_qd) begin
      n_fail++; $display("FAIL bypass t=%0t got %b/%b exp %b/%b", $time, q_hit, q_data, exp_hit, exp_qd);
    end
`endif
    a_acc = a_valid && exp_ar;
    b_acc = b_valid && exp_br;
    if (flush) begin
      mq.delete();
      m_wr_en = 1'b0;
    end else begin
      if (mq.size() > 0) begin
        e         = mq.pop_front();
        m_wr_en   = 1'b1;
        m_wr_addr = e.addr;
        m_wr_data = e.data;
      end else begin
        m_wr_en = 1'b0;
      end
      if (a_acc) mq.push_back('{addr: a_addr, data: a_data});
      if (b_acc) mq.push_back('{addr: b_addr, data: b_data});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (wr_en !== m_wr_en) begin n_fail++; $display("FAIL wr_en t=%0t got %b exp %b", $time, wr_en, m_wr_en); end
    n_checks++;
    if (wr_addr !== m_wr_addr || wr_data !== m_wr_data) begin
      n_fail++; $display("FAIL wr_port t=%0t got %0d/%b exp %0d/%b", $time, wr_addr, wr_data, m_wr_addr, m_wr_data);
    end
    if (wr_en === 1'b1) begin
      dut_rf[wr_addr] = wr_data;
      n_writes++;
    end
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; b_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    idle_inputs();
    a_addr = '0; a_data = 1'b0; b_addr = '0; b_data = 1'b0;
`ifdef PRED_WB_BYPASS_EN
    q_addr = '0;
`endif
    #2 reset_n = 1'b0;
    #10;
    n_checks++;
    if (count !== 3'd0 || wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_state got count=%0d wr_en=%b exp 0/0", count, wr_en); end
    n_checks++;
    if (wr_addr !== '0 || wr_data !== 1'b0 || busy !== '0) begin
      n_fail++; $display("FAIL reset_outputs got addr=%0d data=%b busy=%b exp 0/0/0", wr_addr, wr_data, busy);
    end
    model_reset();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_push();
    a_valid = 1'b1; a_addr = 2'd2; a_data = 1'b1;
    tick();
    a_valid = 1'b0;
    n_checks++;
    if (busy !== 4'b0100) begin n_fail++; $display("FAIL single_busy_queued got %b exp 0100", busy); end
    tick();
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 2'd2 || wr_data !== 1'b1 || busy !== 4'b0100) begin
      n_fail++; $display("FAIL single_write got %b/%0d/%b busy %b exp 1/2/1 busy 0100", wr_en, wr_addr, wr_data, busy);
    end
    tick();
    n_checks++;
    if (wr_en !== 1'b0 || busy !== 4'b0000) begin n_fail++; $display("FAIL single_drain got %b busy %b exp 0 busy 0000", wr_en, busy); end
  endtask

  task automatic test_same_cycle_order();
    for (int i = 0; i < NR; i++) dut_rf[i] = 1'b1;
    a_valid = 1'b1; a_addr = 2'd1; a_data = 1'b1;
    b_valid = 1'b1; b_addr = 2'd1; b_data = 1'b0;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 2'd1 || wr_data !== 1'b1) begin
      n_fail++; $display("FAIL order_first got %b/%0d/%b exp 1/1/1", wr_en, wr_addr, wr_data);
    end
    tick();
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 2'd1 || wr_data !== 1'b0) begin
      n_fail++; $display("FAIL order_second got %b/%0d/%b exp 1/1/0", wr_en, wr_addr, wr_data);
    end
    tick();
    n_checks++;
    if (dut_rf[1] !== 1'b0) begin n_fail++; $display("FAIL order_final got %b exp 0", dut_rf[1]); end
  endtask

  task automatic test_ready_limits();
    a_valid = 1'b1; a_addr = 2'd0; a_data = 1'b1;
    b_valid = 1'b1; b_addr = 2'd3; b_data = 1'b0;
    tick();
    a_addr = 2'd1;
    b_addr = 2'd2;
    tick();
    n_checks++;
    if (count !== 3'd3) begin n_fail++; $display("FAIL ready_count3 got %0d exp 3", count); end
    a_valid = 1'b1; a_addr = 2'd3;
    #1;
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_at3_a got a=%b b=%b exp 1/0", a_ready, b_ready);
    end
    a_valid = 1'b0;
    #1;
    n_checks++;
    if (b_ready !== 1'b1) begin n_fail++; $display("FAIL ready_at3_b_alone got %b exp 1", b_ready); end
    a_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (a_acc) begin a_addr = 2'($urandom_range(0, NR - 1)); a_data = 1'($urandom_range(0, 1)); end
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_flush();
    int writes_before;
    a_valid = 1'b1; a_addr = 2'd2; a_data = 1'b1;
    b_valid = 1'b1; b_addr = 2'd3; b_data = 1'b1;
    tick();
    a_addr = 2'd0; b_addr = 2'd1;
    tick();
    flush = 1'b1;
    writes_before = n_writes;
    tick();
    n_checks++;
    if (count !== 3'd0 || wr_en !== 1'b0 || busy !== '0) begin
      n_fail++; $display("FAIL flush_state got count=%0d wr_en=%b busy=%b exp 0/0/0", count, wr_en, busy);
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (n_writes !== writes_before) begin n_fail++; $display("FAIL flush_no_writes got %0d exp %0d", n_writes - writes_before, 0); end
  endtask

  task automatic test_async_reset();
    a_valid = 1'b1; a_addr = 2'd0; a_data = 1'b1;
    b_valid = 1'b1; b_addr = 2'd2; b_data = 1'b0;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (wr_en !== 1'b1 || count !== 3'd1) begin n_fail++; $display("FAIL areset_pre got wr_en=%b count=%0d exp 1/1", wr_en, count); end
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if (wr_en !== 1'b0 || count !== 3'd0 || busy !== '0) begin
      n_fail++; $display("FAIL areset_immediate got wr_en=%b count=%0d busy=%b exp 0/0/0", wr_en, count, busy);
    end
    #1 reset_n = 1'b1;
    model_reset();
    tick();
  endtask

`ifdef PRED_WB_BYPASS_EN
  task automatic test_bypass();
    a_valid = 1'b1; a_addr = 2'd3; a_data = 1'b0;
    tick();
    a_data = 1'b1;
    tick();
    idle_inputs();
    q_addr = 2'd3;
    #1;
    n_checks++;
    if (q_hit !== 1'b1 || q_data !== 1'b1) begin n_fail++; $display("FAIL bypass_youngest got %b/%b exp 1/1", q_hit, q_data); end
    q_addr = 2'd0;
    #1;
    n_checks++;
    if (q_hit !== 1'b0 || q_data !== 1'b0) begin n_fail++; $display("FAIL bypass_miss got %b/%b exp 0/0", q_hit, q_data); end
    for (int i = 0; i < 3; i++) tick();
  endtask
`endif

  task automatic test_random();
    idle_inputs();
    a_acc = 1'b0;
    b_acc = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!a_valid || a_acc) begin
        a_valid = ($urandom_range(0, 99) < 60);
        a_addr  = 2'($urandom_range(0, NR - 1));
        a_data  = 1'($urandom_range(0, 1));
      end
      if (!b_valid || b_acc) begin
        b_valid = ($urandom_range(0, 99) < 50);
        b_addr  = 2'($urandom_range(0, NR - 1));
        b_data  = 1'($urandom_range(0, 1));
      end
      flush = ($urandom_range(0, 99) < 4);
`ifdef PRED_WB_BYPASS_EN
      q_addr = 2'($urandom_range(0, NR - 1));
`endif
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_writes = 0;
    test_reset();
    test_single_push();
    test_same_cycle_order();
    test_ready_limits();
    test_flush();
    test_async_reset();
`ifdef PRED_WB_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
